// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared receiver state encoding and oversampling indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] c_IDX_S0  = 4'd7;
    localparam logic [3:0] c_IDX_S1  = 4'd8;
    localparam logic [3:0] c_IDX_S2  = 4'd9;
    localparam logic [3:0] c_IDX_END = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_RECOVER = 3'd5
    } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : rx synchronizer and mid-bit 3-sample majority voter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       baud_tick,
    input  logic [3:0] tick_cnt,
    output logic       rx_s,
    output logic       bit_val
);

    logic [1:0] sync_q;
    logic [1:0] samp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            samp_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
            if (baud_tick && (tick_cnt == c_IDX_S0)) samp_q[0] <= sync_q[1];
            if (baud_tick && (tick_cnt == c_IDX_S1)) samp_q[1] <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];

    // Third vote is the live synchronized value, consumed on the index-9 tick.
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

endmodule : uart_rx_sampler
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x-oversampled UART receiver with one-entry holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 baud_tick,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic [3:0]           tick_cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 frame_perr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 oerr_q;

    logic w_rx_s;
    logic w_bit_val;
    logic w_decide;
    logic w_commit;
    logic w_pop;

    uart_rx_sampler u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .baud_tick (baud_tick),
        .tick_cnt  (tick_cnt_q),
        .rx_s      (w_rx_s),
        .bit_val   (w_bit_val)
    );

    assign w_decide = baud_tick && (tick_cnt_q == c_IDX_S2);
    assign w_commit = rx_en && (state_q == ST_STOP) && w_decide && w_bit_val;
    assign w_pop    = valid_q && rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= '0;
            frame_perr_q <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            if (!rx_en) begin
                state_q    <= ST_IDLE;
                tick_cnt_q <= 4'd0;
            end else if (baud_tick) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
                case (state_q)
                    ST_IDLE: begin
                        // The detecting tick is index 0 of the start bit.
                        if (!w_rx_s) begin
                            state_q      <= ST_START;
                            tick_cnt_q   <= 4'd1;
                            bit_cnt_q    <= 3'd0;
                            frame_perr_q <= 1'b0;
                        end else begin
                            tick_cnt_q <= 4'd0;
                        end
                    end
                    ST_START: begin
                        if ((tick_cnt_q == c_IDX_S2) && w_bit_val) begin
                            state_q    <= ST_IDLE;
                            tick_cnt_q <= 4'd0;
                        end else if (tick_cnt_q == c_IDX_END) begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (tick_cnt_q == c_IDX_S2)
                            shreg_q <= {w_bit_val, shreg_q[DATA_BITS-1:1]};
                        if (tick_cnt_q == c_IDX_END) begin
                            if (bit_cnt_q == c_LAST_BIT)
                                state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
                            else
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (tick_cnt_q == c_IDX_S2)
                            frame_perr_q <= w_bit_val ^ (^shreg_q) ^ PARITY_ODD;
                        if (tick_cnt_q == c_IDX_END)
                            state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (tick_cnt_q == c_IDX_S2) begin
                            tick_cnt_q <= 4'd0;
                            if (w_bit_val) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_RECOVER;
                                ferr_q  <= 1'b1;
                            end
                        end
                    end
                    ST_RECOVER: begin
                        // Wait out a break so a held-low line cannot retrigger.
                        tick_cnt_q <= 4'd0;
                        if (w_rx_s) state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        tick_cnt_q <= 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            oerr_q <= 1'b0;
            if (w_commit) begin
                if (!valid_q || rx_ready) begin
                    data_q  <= shreg_q;
                    perr_q  <= frame_perr_q;
                    valid_q <= 1'b1;
                end else begin
                    oerr_q <= 1'b1;
                end
            end else if (w_pop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx (8N1 and 8E1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx, rx_p, rx_en, rx_ready, rx_ready_p;
    logic       baud_tick = 1'b0;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, parity_err, frame_err, overrun_err;
    logic       rx_valid_p, parity_err_p, frame_err_p, overrun_err_p;

    uart_rx u_dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .baud_tick(baud_tick), .rx_en(rx_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dutp (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .baud_tick(baud_tick), .rx_en(rx_en),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
        .parity_err(parity_err_p), .frame_err(frame_err_p), .overrun_err(overrun_err_p)
    );

    int tick_period = 131;
    int tcnt        = 0;
    always @(negedge clk) begin
        if (tcnt >= tick_period - 1) begin
            tcnt      <= 0;
            baud_tick <= 1'b1;
        end else begin
            tcnt      <= tcnt + 1;
            baud_tick <= 1'b0;
        end
    end

    // Pulse/level counters on the 8N1 instance.
    int   v_rise = 0, v_cyc = 0, fe_rise = 0, fe_cyc = 0, oe_rise = 0, oe_cyc = 0;
    logic pv = 1'b0, pfe = 1'b0, poe = 1'b0;
    always @(negedge clk) begin
        if (rx_valid === 1'b1) v_cyc <= v_cyc + 1;
        if (rx_valid === 1'b1 && !pv) v_rise <= v_rise + 1;
        if (frame_err === 1'b1) fe_cyc <= fe_cyc + 1;
        if (frame_err === 1'b1 && !pfe) fe_rise <= fe_rise + 1;
        if (overrun_err === 1'b1) oe_cyc <= oe_cyc + 1;
        if (overrun_err === 1'b1 && !poe) oe_rise <= oe_rise + 1;
        pv  <= (rx_valid === 1'b1);
        pfe <= (frame_err === 1'b1);
        poe <= (overrun_err === 1'b1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        int guard = 0;
        @(posedge clk);
        while (baud_tick !== 1'b1 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 1000) chk("tick_timeout", 32'(guard), 32'd0);
    endtask

    task automatic drive(input bit on_p, input logic v);
        @(negedge clk);
        if (on_p) rx_p = v;
        else      rx   = v;
    endtask

    task automatic send_bit(input bit on_p, input logic v, input int n);
        drive(on_p, v);
        repeat (n) wait_tick();
    endtask

    logic       pre_v, s_v, s_pe, s_fe, s_oe;
    logic [7:0] s_d;

    // Bit edges follow a tick so DUT index 0 is the first tick after each edge.
    task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit,
                              input bit stop_bit, input bit on_p);
        wait_tick();
        send_bit(on_p, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(on_p, d[i], 16);
        if (par_en) send_bit(on_p, par_bit, 16);
        drive(on_p, stop_bit);
        for (int t = 1; t <= 16; t++) begin
            wait_tick();
            if (t == 9) begin
                @(negedge clk);
                pre_v = on_p ? rx_valid_p : rx_valid;
            end
            if (t == 10) begin
                @(negedge clk);
                s_v  = on_p ? rx_valid_p    : rx_valid;
                s_d  = on_p ? rx_data_p     : rx_data;
                s_pe = on_p ? parity_err_p  : parity_err;
                s_fe = on_p ? frame_err_p   : frame_err;
                s_oe = on_p ? overrun_err_p : overrun_err;
            end
        end
    endtask

    int b0, b1, b2, b3;

    initial begin
        rst_n = 1'b0; rx = 1'b1; rx_p = 1'b1; rx_en = 1'b1;
        rx_ready = 1'b1; rx_ready_p = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_oerr", 32'(overrun_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0x55 at 131 clk per tick
        b0 = v_cyc; b1 = fe_rise; b2 = oe_rise;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_pre_valid", 32'(pre_v), 32'd0);
        chk("t1_valid", 32'(s_v), 32'd1);
        chk("t1_data", 32'(s_d), 32'h55);
        chk("t1_valid_width", 32'(v_cyc - b0), 32'd1);
        chk("t1_no_ferr", 32'(fe_rise - b1), 32'd0);
        chk("t1_no_oerr", 32'(oe_rise - b2), 32'd0);

        tick_period = 7;

        // false start
        b0 = v_rise; b1 = fe_rise;
        wait_tick();
        send_bit(1'b0, 1'b0, 4);
        send_bit(1'b0, 1'b1, 40);
        chk("t2_no_valid", 32'(v_rise - b0), 32'd0);
        chk("t2_no_ferr", 32'(fe_rise - b1), 32'd0);
        chk("t2_idle", 32'(u_dut.state_q), 32'(ST_IDLE));
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_valid", 32'(s_v), 32'd1);
        chk("t2_data", 32'(s_d), 32'h3C);

        // framing error with 3 bit-time break
        b0 = v_rise; b1 = fe_rise; b2 = fe_cyc;
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_ferr", 32'(s_fe), 32'd1);
        chk("t3_valid", 32'(s_v), 32'd0);
        repeat (32) wait_tick();
        send_bit(1'b0, 1'b1, 192);
        chk("t3_ferr_once", 32'(fe_rise - b1), 32'd1);
        chk("t3_ferr_width", 32'(fe_cyc - b2), 32'd1);
        chk("t3_no_frame", 32'(v_rise - b0), 32'd0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_next_valid", 32'(s_v), 32'd1);
        chk("t3_next_data", 32'(s_d), 32'h0F);

        // overrun
        @(negedge clk); rx_ready = 1'b0;
        b0 = oe_rise; b1 = oe_cyc;
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_first_valid", 32'(s_v), 32'd1);
        chk("t4_first_data", 32'(s_d), 32'h12);
        chk("t4_first_no_oerr", 32'(s_oe), 32'd0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_oerr", 32'(s_oe), 32'd1);
        chk("t4_kept_data", 32'(s_d), 32'h12);
        chk("t4_oerr_once", 32'(oe_rise - b0), 32'd1);
        chk("t4_oerr_width", 32'(oe_cyc - b1), 32'd1);
        chk("t4_still_valid", 32'(rx_valid), 32'd1);
        chk("t4_still_data", 32'(rx_data), 32'h12);
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk);
        chk("t4_pop", 32'(rx_valid), 32'd0);

        // even parity: 0x07 has odd weight so correct parity bit is 1
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t5_bad_valid", 32'(s_v), 32'd1);
        chk("t5_bad_data", 32'(s_d), 32'h07);
        chk("t5_bad_perr", 32'(s_pe), 32'd1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_good_valid", 32'(s_v), 32'd1);
        chk("t5_good_perr", 32'(s_pe), 32'd0);

        // reset mid data bit 3 with a frame pending
        @(negedge clk); rx_ready = 1'b0;
        send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_pending", 32'(s_v), 32'd1);
        wait_tick();
        send_bit(1'b0, 1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 16);
        send_bit(1'b0, 1'b0, 8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rx_valid), 32'd0);
        chk("t6_rst_data", 32'(rx_data), 32'h00);
        chk("t6_rst_state", 32'(u_dut.state_q), 32'(ST_IDLE));
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b0 = v_rise; b3 = fe_rise;
        repeat (30) wait_tick();
        chk("t6_no_output", 32'(v_rise - b0), 32'd0);
        @(negedge clk); rx_ready = 1'b1;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_pre_valid", 32'(pre_v), 32'd0);
        chk("t6_valid", 32'(s_v), 32'd1);
        chk("t6_data", 32'(s_d), 32'hC3);

        // rx_en dropped mid-frame
        b0 = v_rise;
        wait_tick();
        send_bit(1'b0, 1'b0, 16);
        send_bit(1'b0, 1'b0, 16);
        send_bit(1'b0, 1'b1, 16);
        send_bit(1'b0, 1'b0, 5);
        @(negedge clk);
        rx_en = 1'b0;
        rx = 1'b1;
        repeat (192) wait_tick();
        chk("t7_no_output", 32'(v_rise - b0), 32'd0);
        chk("t7_no_ferr", 32'(fe_rise - b3), 32'd0);
        chk("t7_tick_cnt", 32'(u_dut.tick_cnt_q), 32'd0);
        @(negedge clk); rx_en = 1'b1;
        repeat (4) wait_tick();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t7_valid", 32'(s_v), 32'd1);
        chk("t7_data", 32'(s_d), 32'hC3);

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1-style async serial input (optional parity), clocked from the system clock and paced by the 16x-oversample `baud_tick` produced by `uart_baud_rate`. It synchronizes `rx`, detects and qualifies start bits, takes a majority vote at mid-bit, and shifts data LSB first. Completed frames go into a one-entry holding register with a valid/ready handshake toward the host/USB-side logic. Framing, parity and overrun errors are reported to that logic.

## Interface
- `DATA_BITS`, 8, data bits per frame (5..8)
- `PARITY_EN`, 0, 1 = parity bit expected between data and stop
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even (ignored when `PARITY_EN`=0)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `rx`  in  1  serial line, asynchronous, idle high
- `baud_tick`  in  1  1-cycle pulse at 16x baud, from `uart_baud_rate`
- `rx_en`  in  1  receiver enable
- `rx_data`  out  DATA_BITS  received byte (holding register)
- `rx_valid`  out  1  `rx_data` holds an unread frame
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`
- `parity_err`  out  1  parity mismatch on the frame in `rx_data`, qualified by `rx_valid`
- `frame_err`  out  1  1-cycle pulse: stop bit sampled 0
- `overrun_err`  out  1  1-cycle pulse: good frame dropped because holding register full

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) → `rx_s`. All sampling uses `rx_s`.
- `tick_cnt` (4 bit) indexes baud_ticks within a bit, 0..15. It advances only on `baud_tick`.
- Samples are taken at tick indices 7, 8 and 9. The bit value is the majority of the three. It is decided on the tick-9 edge.
- States:
  - IDLE: on `baud_tick` with `rx_s`=0, go to START. That tick is index 0.
  - START: at index 9, majority 1 → IDLE (false start, no output). Majority 0 → continue. At index 15, go to DATA.
  - DATA: at index 9 of each bit, shift the majority into `shreg` MSB and right-shift, so the result is LSB first. After bit `DATA_BITS-1` index 15, go to PARITY if `PARITY_EN`, otherwise STOP.
  - PARITY: at index 9, compare the majority against the XOR of the data bits (inverted when `PARITY_ODD`). Store the mismatch flag. At index 15, go to STOP.
  - STOP: decide at index 9; there is no wait for index 15.
    - Majority 1: commit and go to IDLE.
    - Majority 0: pulse `frame_err`, discard the frame, go to RECOVER.
  - RECOVER: wait for `rx_s`=1, sampled on `baud_tick`, then go to IDLE. This prevents a break from retriggering.
- Commit:
  - Holding register empty, or popped in the same cycle: load `rx_data`/`parity_err` and set `rx_valid`.
  - Otherwise: keep the old data and pulse `overrun_err`.
- Pop: `rx_valid && rx_ready` clears `rx_valid` on that edge unless a commit coincides, in which case the new frame loads and `rx_valid` stays 1.
- `rx_en`=0: state → IDLE and `tick_cnt` → 0 synchronously. The in-flight frame is abandoned. The holding register and handshake keep working.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0.
  - State IDLE, `tick_cnt`=0, synchronizer = 1.
- `rst_n` asserted mid-frame aborts immediately. The first frame after release starts cleanly.
- Input latency is 2 clk through the synchronizer.
- `rx_valid` rises on the clk edge that samples the stop bit's index-9 `baud_tick`. `frame_err` and `overrun_err` pulse on that same edge for exactly one cycle.
- Back-to-back frames are supported: the next start edge is accepted from the first `baud_tick` after commit.
- Tolerance is ±3/16 bit of sampling-point drift across the frame.
- No combinational path from any input to any output.

## Structure
- `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP, RECOVER)
  - `OVERSAMPLE`=16
  - sample indices 7/8/9, end index 15
- One sub-module `uart_rx_sampler` contains:
  - the 2-flop synchronizer
  - the 3-sample majority voter
  - outputs `rx_s` and `bit_val`, with inputs `baud_tick`/`tick_cnt`
- FSM, shift register and holding register live in `uart_rx`.

## Test plan
- 0x55, 8N1, `baud_tick` every 131 clk, `rx_ready`=1 → `rx_valid` 1 cycle, `rx_data`=0x55, no error pulses.
- `rx` low for 4 ticks then high → no `rx_valid`, state back to IDLE. A following 0x3C frame is received correctly.
- 0xA3 with stop bit 0, line held low for 3 bit-times → one `frame_err` pulse, `rx_valid` stays 0, no frame accepted until `rx` returns high. The next 0x0F is received.
- 0x12 then 0x34 with `rx_ready`=0 → `rx_data`=0x12 kept and `overrun_err` pulses at the 0x34 stop. Then `rx_ready`=1 → `rx_valid` falls the next cycle.
- `PARITY_EN`=1 even, 0x07 with parity bit 0 → `rx_valid`=1 with `parity_err`=1. Same frame with parity bit 1 → `parity_err`=0.
- `rst_n` pulsed low during DATA bit 3, and separately `rx_en` dropped mid-frame → no output from the aborted frame, all outputs at reset values after `rst_n`, next 0xC3 received correctly.
